haar_pair_stream: RTL and testbench
===================================

Name: haar_pair_stream

Overview:
- Upstream feeder for the Haar average stage (haardif, out = (a+b)/2).
- Accepts a serial pixel stream with valid/ready handshake and groups adjacent samples into (even, odd) pairs.
- Presents each pair on registered a/b outputs with its own valid/ready handshake.
- Marks row ends and pads odd-length rows by duplicating the last pixel, so the average stage always sees complete pairs.

Parameters:
- DATA_W, 8, pixel width; pair_a/pair_b match the average stage input width.
- CNT_W, 16, width of the per-row pair counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block accepts the input this cycle (transfer = in_valid & in_ready).
- in_data  input  DATA_W  pixel sample.
- in_last  input  1  final pixel of the current row.
- pair_valid  output  1  pair outputs hold a valid pair.
- pair_ready  input  1  downstream accepts the pair (transfer = pair_valid & pair_ready).
- pair_a  output  DATA_W  even (first) sample.
- pair_b  output  DATA_W  odd (second) sample, or copy of pair_a when padded.
- pair_last  output  1  this pair closes the row.
- pair_pad  output  1  pair_b is a duplicate (odd-length row).
- pair_idx  output  CNT_W  index of this pair within its row, starting at 0.

Behaviour:
- Reset (sync, rst=1 at clk edge): state=EVEN, pair_valid=0, pair_a=0, pair_b=0, pair_last=0, pair_pad=0, pair_idx=0, internal hold reg=0, row pair counter=0.
  - Any half-collected pair or unaccepted output pair is discarded.
  - rst dominates all other inputs in the same cycle.
- slot_free = !pair_valid | pair_ready. The output register may be reloaded in the same cycle it is consumed.
- State EVEN:
  - in_ready=1.
  - On transfer: hold <= in_data.
  - If in_last=0, go to ODD.
  - If in_last=1, go to PAD.
- State ODD:
  - in_ready=slot_free.
  - On transfer: pair_a<=hold, pair_b<=in_data, pair_last<=in_last, pair_pad<=0, pair_idx<=counter, pair_valid<=1.
  - Counter <= in_last ? 0 : counter+1. Go to EVEN.
- State PAD:
  - in_ready=0.
  - When slot_free: pair_a<=hold, pair_b<=hold, pair_last<=1, pair_pad<=1, pair_idx<=counter, pair_valid<=1.
  - Counter<=0. Go to EVEN.
- Output clear: if pair_ready & pair_valid and no new pair loads this cycle, pair_valid<=0. The other output fields keep their values.
- Stable outputs: while pair_valid=1 and pair_ready=0, all pair_* outputs hold stable.
- in_ready may depend on pair_ready combinationally. It never depends on in_valid or in_data.
- Latency: the pair appears on the cycle after the odd sample is accepted (or after PAD resolves).
- Throughput: one input per cycle sustained. One pair every 2 cycles with pair_ready held high.
- in_last on an odd sample closes the row normally (pair_pad=0).
- Counter wraps modulo 2^CNT_W. No error is flagged.
- Data passes through unmodified. There is no arithmetic; width is preserved.

Decomposition:
- Package haar_pkg:
  - DATA_W default.
  - State enum {EVEN, ODD, PAD} (2-bit).
  - Shared pair struct type (a, b, last, pad, idx) for reuse by the average/difference stages.
- Sub-module haar_pair_reg: a one-entry output holding register with valid/ready and the slot_free logic. The FSM and hold register stay in the top module.

Test Plan:
- Row 10,20,30,40 (last on 40), pair_ready=1 -> pairs (10,20,idx0,last0,pad0) then (30,40,idx1,last1,pad0); in_ready high throughout.
- Row 5,7,9 (last on 9) -> (5,7,idx0) then (9,9,idx1,last1,pad1); in_ready=0 for exactly one cycle in PAD.
- Single-pixel row 255 with last -> (255,255,idx0,last1,pad1); the next row's first pair restarts at idx0.
- Backpressure: pair_ready=0 for 5 cycles after the first pair of 1,2,3,4 -> pair (1,2) held stable; 3 accepted; in_ready=0 while offering 4; (3,4) loads the cycle pair_ready rises.
- rst asserted while in ODD holding 0xAA with an unaccepted pair out -> next cycle pair_valid=0, all outputs 0, in_ready=1; the next sample 0x11 is treated as an even sample.
- Random valid/ready toggling over 1000 pixels with random row lengths (1-17) -> scoreboard match on every pair, idx, last and pad; no loss or duplication.

Source files
------------

// File: rtl/haar_pkg.sv
// Shared types for the Haar pairing/average/difference stages.
// pair_t uses the default widths so later stages can pass whole pairs around.
package haar_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EVEN = 2'd0,
    ODD  = 2'd1,
    PAD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic                  last;
    logic                  pad;
    logic [CNT_W_DEF-1:0]  idx;
  } pair_t;

endpackage

// File: rtl/haar_pair_stream_if.sv
// Pixel-in / pair-out handshake bundle for haar_pair_stream.
// The slave modport is the block's view of the bundle; the master modport is the driver's view.
interface haar_pair_stream_if #(
  parameter int DATA_W = haar_pkg::DATA_W_DEF,
  parameter int CNT_W  = haar_pkg::CNT_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              pair_valid;
  logic              pair_ready;
  logic [DATA_W-1:0] pair_a;
  logic [DATA_W-1:0] pair_b;
  logic              pair_last;
  logic              pair_pad;
  logic [CNT_W-1:0]  pair_idx;

  modport slave (
    input  in_valid, in_data, in_last, pair_ready,
    output in_ready, pair_valid, pair_a, pair_b, pair_last, pair_pad, pair_idx
  );

  modport master (
    output in_valid, in_data, in_last, pair_ready,
    input  in_ready, pair_valid, pair_a, pair_b, pair_last, pair_pad, pair_idx
  );

endinterface

// File: rtl/haar_pair_reg.sv
// One-entry output holding register with valid/ready handshake.
// The register can be refilled in the same cycle its current entry is taken.
module haar_pair_reg #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         slot_free
);

  assign slot_free = !valid || ready;

  // NOTE: clocked state is assigned with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/haar_pair_stream.sv
// Groups a serial pixel stream into (even, odd) pairs for the Haar average stage.
// Odd-length rows are closed with a padded pair that duplicates the last pixel.
module haar_pair_stream
  import haar_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  haar_pair_stream_if.slave  bus
);

  localparam int PW = 2 * DATA_W + 2 + CNT_W;

  state_e            state;
  logic [DATA_W-1:0] hold;
  logic [CNT_W-1:0]  cnt;

  logic              in_ready;
  logic              slot_free;
  logic              xfer;
  logic              load;
  logic [PW-1:0]     load_word;
  logic [PW-1:0]     out_word;

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned.
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      EVEN:    in_ready = 1'b1;
      ODD:     in_ready = slot_free;
      PAD:     in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign xfer         = bus.in_valid && in_ready;
  assign load         = ((state == ODD) && xfer) || ((state == PAD) && slot_free);

  // A padded pair repeats the held pixel and always closes the row.
  always_comb begin
    load_word = {hold, bus.in_data, bus.in_last, 1'b0, cnt};
    if (state == PAD) begin
      load_word = {hold, hold, 1'b1, 1'b1, cnt};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EVEN;
      hold  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        EVEN: begin
          if (xfer) begin
            hold  <= bus.in_data;
            state <= bus.in_last ? PAD : ODD;
          end
        end
        ODD: begin
          if (xfer) begin
            cnt   <= bus.in_last ? '0 : cnt + CNT_W'(1);
            state <= EVEN;
          end
        end
        PAD: begin
          if (slot_free) begin
            cnt   <= '0;
            state <= EVEN;
          end
        end
        default: state <= EVEN;
      endcase
    end
  end

  haar_pair_reg #(.W(PW)) u_pair_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (load_word),
    .ready     (bus.pair_ready),
    .valid     (bus.pair_valid),
    .dout      (out_word),
    .slot_free (slot_free)
  );

  assign {bus.pair_a, bus.pair_b, bus.pair_last, bus.pair_pad, bus.pair_idx} = out_word;

endmodule

// File: tb/tb_haar_pair_stream.sv
// Directed and randomised-handshake bench for haar_pair_stream.
// Accepted pairs are captured on the falling edge and compared against hand-derived pairs.
module tb_haar_pair_stream;
  import haar_pkg::*;

  logic clk = 1'b0;
  logic rst;

  haar_pair_stream_if #(.DATA_W(DATA_W_DEF), .CNT_W(CNT_W_DEF)) bus ();

  haar_pair_stream #(.DATA_W(DATA_W_DEF), .CNT_W(CNT_W_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    stall_cnt = 0;
  logic  stall_prev = 1'b0;
  pair_t prev_pair;
  pair_t got_q[$];
  pair_t exp_q[$];
  logic  rand_done;

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got_v, exp_v);
  endtask

  function automatic pair_t cur_pair();
    pair_t p;
    p = {bus.pair_a, bus.pair_b, bus.pair_last, bus.pair_pad, bus.pair_idx};
    return p;
  endfunction

  function automatic pair_t mk(input logic [7:0] a, input logic [7:0] b,
                               input int idx, input logic last, input logic pad);
    pair_t p;
    p = {a, b, last, pad, 16'(idx)};
    return p;
  endfunction

  // Falling-edge monitor: capture accepted pairs, count input stalls, check held pairs stay put.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) check("hold_stable", cur_pair(), prev_pair);
      stall_prev <= bus.pair_valid & ~bus.pair_ready;
      prev_pair  <= cur_pair();
      if (bus.pair_valid && bus.pair_ready) got_q.push_back(cur_pair());
      if (bus.in_valid && !bus.in_ready) stall_cnt <= stall_cnt + 1;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", bus.in_ready, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    int w;
    w = 0;
    do begin
      @(posedge clk);
      w++;
    end while (got_q.size() < n && w < 4000);
    #1;
    check({tag, "_count"}, got_q.size(), n);
  endtask

  task automatic expect_pair(input string tag, input pair_t e);
    if (got_q.size() > 0) check(tag, got_q.pop_front(), e);
    else check({tag, "_missing"}, got_q.size(), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit hit with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int st0;
    int remaining;
    int len;
    logic [7:0] px [17];

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.pair_ready = 1'b0;
    rand_done      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_valid", bus.pair_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_pair", cur_pair(), 0);

    // Even-length row with downstream always ready
    bus.pair_ready = 1'b1;
    st0 = stall_cnt;
    send(8'd10, 0); send(8'd20, 0); send(8'd30, 0); send(8'd40, 1);
    drain("row4", 2);
    check("row4_stalls", stall_cnt - st0, 0);
    expect_pair("row4_p0", mk(8'd10, 8'd20, 0, 0, 0));
    expect_pair("row4_p1", mk(8'd30, 8'd40, 1, 1, 0));

    // Odd row, single-pixel row, then a fresh row restarting at idx 0
    st0 = stall_cnt;
    send(8'd5, 0); send(8'd7, 0); send(8'd9, 1);
    send(8'd255, 1);
    send(8'd60, 0); send(8'd61, 1);
    drain("odd", 4);
    check("odd_pad_stalls", stall_cnt - st0, 2);
    expect_pair("odd_p0", mk(8'd5, 8'd7, 0, 0, 0));
    expect_pair("odd_pad", mk(8'd9, 8'd9, 1, 1, 1));
    expect_pair("single", mk(8'd255, 8'd255, 0, 1, 1));
    expect_pair("restart", mk(8'd60, 8'd61, 0, 1, 0));

    // Backpressure: pair (1,2) held while 4 is offered
    bus.pair_ready = 1'b0;
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd4;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_held", cur_pair(), mk(8'd1, 8'd2, 0, 0, 0));
      check("bp_valid", bus.pair_valid, 1);
      @(posedge clk);
      #1;
    end
    bus.pair_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_reload", cur_pair(), mk(8'd3, 8'd4, 1, 1, 0));
    check("bp_reload_valid", bus.pair_valid, 1);
    drain("bp", 2);
    expect_pair("bp_p0", mk(8'd1, 8'd2, 0, 0, 0));
    expect_pair("bp_p1", mk(8'd3, 8'd4, 1, 1, 0));

    // Reset in ODD with an unaccepted pair on the output
    bus.pair_ready = 1'b0;
    send(8'h01, 0); send(8'h02, 0); send(8'hAA, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst2_valid", bus.pair_valid, 0);
    check("rst2_pair", cur_pair(), 0);
    check("rst2_in_ready", bus.in_ready, 1);
    bus.pair_ready = 1'b1;
    send(8'h11, 0); send(8'h12, 1);
    drain("rst2", 1);
    expect_pair("rst2_even", mk(8'h11, 8'h12, 0, 1, 0));

    // Random rows with random valid gaps and ready toggling
    remaining = 1000;
    while (remaining > 0) begin
      len = $urandom_range(1, 17);
      if (len > remaining) len = remaining;
      for (int i = 0; i < len; i++) px[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < len; i += 2) begin
        if (i + 1 < len) exp_q.push_back(mk(px[i], px[i+1], i / 2, (i + 2 >= len), 0));
        else             exp_q.push_back(mk(px[i], px[i], i / 2, 1, 1));
      end
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        fork
          begin
            if (i == 0 && remaining == 1000) begin
              fork
                begin
                  while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    if (!rand_done) bus.pair_ready = ($urandom_range(0, 1) == 1);
                  end
                end
              join_none
            end
          end
        join
        send(px[i], (i == len - 1));
      end
      remaining -= len;
    end
    rand_done = 1'b1;
    @(posedge clk);
    #1;
    bus.pair_ready = 1'b1;
    drain("rand", exp_q.size());
    while (exp_q.size() > 0) expect_pair("rand_pair", exp_q.pop_front());
    check("rand_extra", got_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
